move_scanner: RTL and testbench
===============================

# move_scanner

Sequential move collector that sits directly downstream of the 64 `square` cells. It walks the board one square at a time, reads that square's 16 move-register words (8 sliding/step rays plus 8 knight rays), and filters those owned by the engine colour. It emits the filtered moves one per handshake as {from, to, piece} records to the move-ordering and search logic.

## Interface
Parameters:
- `NUM_SQUARES`, default 64: number of squares scanned, indices 0..NUM_SQUARES-1.
- `SQ_W`, default 6: square index width.

Ports:
- `clk`  in  1: the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a scan. Ignored while `busy`.
- `engineColor`  in  1: side to move, 1 = WHITE, 0 = BLACK. Latched on an accepted `start`.
- `sq_sel`  out  SQ_W: index of the square whose moves are being read.
- `move_bus`  in  152: move words of the selected square.
  - [87:0] holds 8 × 11-bit words U,D,L,R,UL,UR,DL,DR, with U in the LSBs. Each word is {color, attack[3:0], from[5:0]}.
  - [151:88] holds 8 × 8-bit words UUL,UUR,LLU,RRU,DDL,DDR,LLD,RRD, with UUL lowest. Each word is {color, knight, from[5:0]}.
- `mv_valid`  out  1: an output move is presented.
- `mv_ready`  in  1: downstream accepts the move.
- `mv_from`  out  6: origin square of the move.
- `mv_to`  out  6: destination square, equal to `sq_sel`.
- `mv_piece`  out  4: attack code (1000 rook, 0100 bishop, 1100 queen, 0010 king, 0001 pawn). 0000 for a knight move.
- `mv_knight`  out  1: move comes from a knight ray.
- `busy`  out  1: a scan is in progress.
- `done`  out  1: one-cycle pulse when the scan completes.
- `move_count`  out  8: moves accepted in the current or last scan, saturating at 255.

## Operation
- States are IDLE, SELECT, LOAD, EMIT and DONE.
- **IDLE**: on `start`, latch `engineColor`, set `sq_sel`=0, clear `move_count`, go to SELECT.
- **SELECT**: hold for one cycle so the addressed square can present `move_bus`.
- **LOAD**: register all 16 words and build a 16-bit pending mask. Mask bit i is the word at priority i (U=0 … RRD=15). Go to EMIT.
  - A sliding word is valid when attack≠0000 and color==latched colour.
  - A knight word is valid when knight=1 and color==latched colour.
- **EMIT**:
  - If the mask is non-zero, present the lowest set bit's word with `mv_valid`=1. When `mv_valid`&&`mv_ready`, clear that bit and increment `move_count` (saturating).
  - If the mask is zero, `mv_valid`=0. If `sq_sel`==NUM_SQUARES-1 go to DONE; otherwise increment `sq_sel` and go to SELECT.
- **DONE**: assert `done` for one cycle, then go to IDLE. `busy` is 1 in every state except IDLE.
- Output stability: while `mv_valid`=1 and `mv_ready`=0, `mv_from`, `mv_to`, `mv_piece` and `mv_knight` hold unchanged.
- `move_bus` is sampled only in LOAD. Changes in any other state have no effect.

## Timing
- Reset values: state IDLE, `sq_sel`=0, `mv_valid`=0, `mv_from`=0, `mv_to`=0, `mv_piece`=0, `mv_knight`=0, `busy`=0, `done`=0, `move_count`=0, mask=0.
- Read latency: `move_bus` must be valid in the cycle after `sq_sel` changes. It is captured at the end of LOAD, which is the second cycle on that square.
- Cost per square is 3 + k cycles, where k is the number of moves emitted, assuming `mv_ready` is held high.
- Empty-board scan: the `start` edge enters SELECT, and `done` is high 193 cycles after that edge (64 × 3 + 1).
- `mv_ready` stalls add cycles one-for-one. There is no bubble between consecutive moves of the same square.
- `start` asserted during `busy` is dropped and not queued.
- `rst` mid-scan returns to IDLE immediately. `mv_valid` drops asynchronously and no `done` is produced.
- `move_count` saturates at 255. `mv_valid` continues regardless of saturation.

## Configuration
- With `KNIGHT_SCAN_EN` defined: knight words [151:88] are decoded as described above.
- Without `KNIGHT_SCAN_EN`:
  - Mask bits 15:8 are forced to 0 and `mv_knight` is tied to 0.
  - Knight input bits are unused, so only sliding and step moves are emitted.
  - Per-square timing is otherwise unchanged.

## Test plan
- **Empty board**: `move_bus`=0 everywhere, then pulse `start`. Require `mv_valid` never asserted, `done` high exactly 193 cycles after `start`, and `move_count`=0.
- **Square 28, engine BLACK, `mv_ready`=1**: bus non-zero only when `sq_sel`=28, with D={0,1000,20}, L={0,1100,29}, DL={0,0100,21}, UUR={0,1,43}. Require four moves in order: (20→28, 1000), (29→28, 1100), (21→28, 0100), (43→28, knight). Require `move_count`=4.
- **Same stimulus with `engineColor`=WHITE**: require no moves emitted and `move_count`=0.
- **Backpressure**: repeat the square-28 case with `mv_ready` held low for 5 cycles on the first move. Require the first record to stay stable for those 5 cycles, then the same 4-move order.
- **`start` during `busy` and `rst` mid-EMIT**:
  - A `start` pulse while `busy` is ignored and `sq_sel` is not reset.
  - `rst` asserted while `mv_valid`=1 forces `mv_valid`=0, `busy`=0 and `sq_sel`=0 without a clock edge.
- **Macro off**: build without `KNIGHT_SCAN_EN` and run the square-28 case. Require 3 moves only (UUR suppressed) and `move_count`=3.

Source files
------------

// File: rtl/move_scanner_if.sv
// move_scanner_if: move-record handshake between move_scanner and the move-ordering logic.
//   mv_valid  : a move record is presented
//   mv_ready  : downstream accepts the presented record
//   mv_from   : origin square of the move
//   mv_to     : destination square (the square being scanned)
//   mv_piece  : attack code of the mover, 0000 for knight moves
//   mv_knight : record comes from a knight ray
// Modports: master = producer (move_scanner), slave = consumer.
interface move_scanner_if;
  logic       mv_valid;
  logic       mv_ready;
  logic [5:0] mv_from;
  logic [5:0] mv_to;
  logic [3:0] mv_piece;
  logic       mv_knight;

  modport master (
    output mv_valid,
    output mv_from,
    output mv_to,
    output mv_piece,
    output mv_knight,
    input  mv_ready
  );

  modport slave (
    input  mv_valid,
    input  mv_from,
    input  mv_to,
    input  mv_piece,
    input  mv_knight,
    output mv_ready
  );
endinterface

// File: rtl/move_scanner.sv
// move_scanner: walks the board one square at a time, captures that square's 16 move-register
// words (8 sliding/step rays, 8 knight rays), keeps those owned by the engine colour and emits
// them one per handshake as {from, to, piece} records.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begins a scan (ignored while busy)
//   engineColor  : side to move (1 = white), latched on an accepted start
//   sq_sel       : index of the square being read
//   move_bus     : move words of the selected square ([87:0] sliding, [151:88] knight)
//   mv           : move-record handshake (move_scanner_if master)
//   busy, done   : scan in progress / one-cycle completion pulse
//   move_count   : moves accepted in the current or last scan, saturating at 255
//
// Build option: define KNIGHT_SCAN_EN to decode the knight words; without it only sliding
// and step moves are emitted and mv_knight is tied low.
module move_scanner #(
  parameter int unsigned NUM_SQUARES = 64,
  parameter int unsigned SQ_W        = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              engineColor,
  output logic [SQ_W-1:0]   sq_sel,
  input  logic [151:0]      move_bus,
  move_scanner_if.master    mv,
  output logic              busy,
  output logic              done,
  output logic [7:0]        move_count
);

  localparam logic [SQ_W-1:0] LastSq = SQ_W'(NUM_SQUARES - 1);

  typedef enum logic [2:0] {StIdle, StSelect, StLoad, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic              color_q, color_d;
  logic [SQ_W-1:0]   sq_sel_q, sq_sel_d;
  logic [7:0]        count_q, count_d;
  logic [15:0]       mask_q, mask_d;
  logic [15:0]       load_mask;
  logic [3:0]        sel_idx;
  logic              emit_valid;

  logic [5:0]        slide_from_q [8];
  logic [3:0]        piece_q      [8];
`ifdef KNIGHT_SCAN_EN
  logic [5:0]        knight_from_q [8];
`else
  logic              unused_knight_bus;
  assign unused_knight_bus = ^move_bus[151:88];
`endif

  // Pending mask built from the live bus; only registered in LOAD.
  always_comb begin
    load_mask = '0;
    for (int i = 0; i < 8; i++) begin
      load_mask[i] = (move_bus[11*i+6 +: 4] != 4'd0) && (move_bus[11*i+10] == color_q);
`ifdef KNIGHT_SCAN_EN
      load_mask[8+i] = move_bus[88+8*i+6] && (move_bus[88+8*i+7] == color_q);
`endif
    end
  end

  // Lowest set mask bit has priority.
  always_comb begin
    sel_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i]) sel_idx = 4'(i);
    end
  end

  assign emit_valid = (state_q == StEmit) && (mask_q != 16'd0);

  always_comb begin
    state_d  = state_q;
    color_d  = color_q;
    sq_sel_d = sq_sel_q;
    count_d  = count_q;
    mask_d   = mask_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          color_d  = engineColor;
          sq_sel_d = '0;
          count_d  = 8'd0;
          state_d  = StSelect;
        end
      end
      // Gives the addressed square a cycle to drive move_bus.
      StSelect: state_d = StLoad;
      StLoad: begin
        mask_d  = load_mask;
        state_d = StEmit;
      end
      StEmit: begin
        if (mask_q != 16'd0) begin
          if (mv.mv_ready) begin
            mask_d = mask_q & ~(16'd1 << sel_idx);
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
          end
        end else if (sq_sel_q == LastSq) begin
          state_d = StDone;
        end else begin
          sq_sel_d = sq_sel_q + SQ_W'(1);
          state_d  = StSelect;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      color_q  <= 1'b0;
      sq_sel_q <= '0;
      count_q  <= 8'd0;
      mask_q   <= 16'd0;
      for (int i = 0; i < 8; i++) begin
        slide_from_q[i] <= 6'd0;
        piece_q[i]      <= 4'd0;
`ifdef KNIGHT_SCAN_EN
        knight_from_q[i] <= 6'd0;
`endif
      end
    end else begin
      state_q  <= state_d;
      color_q  <= color_d;
      sq_sel_q <= sq_sel_d;
      count_q  <= count_d;
      mask_q   <= mask_d;
      if (state_q == StLoad) begin
        for (int i = 0; i < 8; i++) begin
          slide_from_q[i] <= move_bus[11*i +: 6];
          piece_q[i]      <= move_bus[11*i+6 +: 4];
`ifdef KNIGHT_SCAN_EN
          knight_from_q[i] <= move_bus[88+8*i +: 6];
`endif
        end
      end
    end
  end

  // Record fields come straight from registers, so they hold while the consumer stalls.
  always_comb begin
    mv.mv_valid  = emit_valid;
    mv.mv_from   = 6'd0;
    mv.mv_to     = 6'd0;
    mv.mv_piece  = 4'd0;
    mv.mv_knight = 1'b0;
    if (emit_valid) begin
      mv.mv_to = 6'(sq_sel_q);
      if (sel_idx[3]) begin
`ifdef KNIGHT_SCAN_EN
        mv.mv_from   = knight_from_q[sel_idx[2:0]];
        mv.mv_knight = 1'b1;
`endif
      end else begin
        mv.mv_from  = slide_from_q[sel_idx[2:0]];
        mv.mv_piece = piece_q[sel_idx[2:0]];
      end
    end
  end

  assign sq_sel     = sq_sel_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign move_count = count_q;

endmodule

// File: tb/tb_move_scanner.sv
module tb_move_scanner;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         engine_color;
  logic [5:0]   sq_sel;
  logic [151:0] move_bus;
  logic         busy;
  logic         done;
  logic [7:0]   move_count;

  logic [151:0] board [64];
  logic [16:0]  exp_q [$];
  int           checks = 0;
  int           errors = 0;

`ifdef KNIGHT_SCAN_EN
  localparam int Sq28Moves = 4;
`else
  localparam int Sq28Moves = 3;
`endif

  move_scanner_if mv();

  move_scanner #(.NUM_SQUARES(64), .SQ_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .engineColor(engine_color),
    .sq_sel     (sq_sel),
    .move_bus   (move_bus),
    .mv         (mv),
    .busy       (busy),
    .done       (done),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  assign move_bus = board[sq_sel];

  // Reference: every owned, valid word of every square in ray priority order.
  // Record = {knight, piece, to, from}.
  function automatic void build_expected(input logic color);
    logic [10:0] w;
    logic [7:0]  k;
    exp_q.delete();
    for (int s = 0; s < 64; s++) begin
      for (int i = 0; i < 8; i++) begin
        w = board[s][11*i +: 11];
        if (w[9:6] != 4'd0 && w[10] == color) exp_q.push_back({1'b0, w[9:6], 6'(s), w[5:0]});
      end
`ifdef KNIGHT_SCAN_EN
      for (int i = 0; i < 8; i++) begin
        k = board[s][88+8*i +: 8];
        if (k[6] && k[7] == color) exp_q.push_back({1'b1, 4'd0, 6'(s), k[5:0]});
      end
`endif
    end
  endfunction

  task automatic clear_board();
    for (int s = 0; s < 64; s++) board[s] = '0;
  endtask

  task automatic set_sq28();
    logic [151:0] b;
    clear_board();
    b = '0;
    b[11 +: 11] = {1'b0, 4'b1000, 6'd20};  // D
    b[22 +: 11] = {1'b0, 4'b1100, 6'd29};  // L
    b[66 +: 11] = {1'b0, 4'b0100, 6'd21};  // DL
    b[96 +: 8]  = {1'b0, 1'b1, 6'd43};     // UUR
    board[28] = b;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 5 cycles on the first move
  task automatic run_scan(input logic color, input int mode, output int emitted,
                          output int cycles, output bit got_done);
    logic [16:0] rec, prev_rec, want;
    bit          stalled;
    bit          r;
    int          stall_cnt;
    build_expected(color);
    emitted = 0; cycles = 0; got_done = 0; stalled = 0; stall_cnt = 0; prev_rec = '0;
    @(negedge clk);
    engine_color = color;
    start = 1'b1;
    mv.mv_ready = 1'b1;
    while (!got_done && cycles < 5000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start = 1'b0;
      if (mv.mv_valid) begin
        rec = {mv.mv_knight, mv.mv_piece, mv.mv_to, mv.mv_from};
        if (stalled) begin
          checks++;
          if (rec !== prev_rec) begin
            errors++;
            $display("FAIL hold_stable: got %h required %h", rec, prev_rec);
          end
        end
        case (mode)
          0: r = 1'b1;
          1: r = ($urandom_range(0, 3) != 0);
          default: begin
            if (emitted == 0 && stall_cnt < 5) begin
              r = 1'b0;
              stall_cnt++;
            end else begin
              r = 1'b1;
            end
          end
        endcase
        mv.mv_ready = r;
        if (r) begin
          stalled = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL move_order: got %h required no further move", rec);
          end else begin
            want = exp_q.pop_front();
            if (rec !== want) begin
              errors++;
              $display("FAIL move_order: got %h required %h", rec, want);
            end
          end
          emitted++;
        end else begin
          stalled = 1;
          prev_rec = rec;
        end
      end else begin
        stalled = 0;
        mv.mv_ready = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      if (done) got_done = 1;
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL scan_done: got timeout after %0d cycles required done", cycles);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL moves_missing: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; engine_color = 1'b0; mv.mv_ready = 1'b1;
    clear_board();
    repeat (2) @(negedge clk);
    checks++;
    if ({mv.mv_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000", {mv.mv_valid, busy, done});
    end
    checks++;
    if (sq_sel !== 6'd0 || move_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got sq %0d cnt %0d required 0 0", sq_sel, move_count);
    end
    checks++;
    if ({mv.mv_from, mv.mv_to, mv.mv_piece, mv.mv_knight} !== 17'd0) begin
      errors++;
      $display("FAIL reset_record: got %h required 0",
               {mv.mv_from, mv.mv_to, mv.mv_piece, mv.mv_knight});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy %b required 0", busy);
    end
  endtask

  task automatic test_empty();
    int  n, cyc;
    bit  ok;
    clear_board();
    run_scan(1'b1, 0, n, cyc, ok);
    checks++;
    if (cyc != 193) begin
      errors++;
      $display("FAIL empty_latency: got %0d required 193", cyc);
    end
    checks++;
    if (n != 0 || move_count !== 8'd0) begin
      errors++;
      $display("FAIL empty_moves: got %0d cnt %0d required 0 0", n, move_count);
    end
  endtask

  task automatic test_sq28(input logic color, input int mode);
    int n, cyc, want;
    bit ok;
    set_sq28();
    want = (color == 1'b0) ? Sq28Moves : 0;
    run_scan(color, mode, n, cyc, ok);
    checks++;
    if (n != want || move_count !== 8'(want)) begin
      errors++;
      $display("FAIL sq28_count: got %0d cnt %0d required %0d", n, move_count, want);
    end
    checks++;
    if (cyc != 193 + want + ((mode == 2 && want > 0) ? 5 : 0)) begin
      errors++;
      $display("FAIL sq28_latency: got %0d cycles required %0d", cyc,
               193 + want + ((mode == 2 && want > 0) ? 5 : 0));
    end
  endtask

  task automatic test_random();
    logic [159:0] tmp;
    logic         color;
    int           n, cyc, want;
    bit           ok;
    for (int t = 0; t < 4; t++) begin
      clear_board();
      for (int s = 0; s < 64; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
          board[s] = tmp[151:0];
        end
      end
      color = 1'($urandom_range(0, 1));
      build_expected(color);
      want = exp_q.size();
      run_scan(color, 1, n, cyc, ok);
      checks++;
      if (n != want || move_count !== 8'((want > 255) ? 255 : want)) begin
        errors++;
        $display("FAIL random_count: got %0d cnt %0d required %0d", n, move_count, want);
      end
    end
  endtask

  task automatic test_saturation();
    logic [151:0] b;
    int           n, cyc, want;
    bit           ok;
    for (int s = 0; s < 64; s++) begin
      b = '0;
      for (int i = 0; i < 8; i++) begin
        b[11*i +: 11]  = {1'b1, 4'b1000, 6'($urandom_range(0, 63))};
        b[88+8*i +: 8] = {1'b1, 1'b1, 6'($urandom_range(0, 63))};
      end
      board[s] = b;
    end
`ifdef KNIGHT_SCAN_EN
    want = 1024;
`else
    want = 512;
`endif
    run_scan(1'b1, 0, n, cyc, ok);
    checks++;
    if (move_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate: got %0d required 255", move_count);
    end
    checks++;
    if (n != want) begin
      errors++;
      $display("FAIL saturate_emitted: got %0d required %0d", n, want);
    end
  endtask

  task automatic test_start_busy();
    int         cyc;
    logic [5:0] rec_sq;
    clear_board();
    mv.mv_ready = 1'b1;
    @(negedge clk);
    engine_color = 1'b0;
    start = 1'b1;
    cyc = 0;
    repeat (21) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    rec_sq = sq_sel;
    start = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (!(sq_sel >= rec_sq && sq_sel != 6'd0) || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: got sq %0d busy %b required >= %0d busy 1", sq_sel, busy, rec_sq);
    end
    while (!done && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != 193) begin
      errors++;
      $display("FAIL start_busy_latency: got %0d required 193", cyc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_not_queued: got busy %b required 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    int cyc;
    bit saw_done;
    set_sq28();
    @(negedge clk);
    engine_color = 1'b0;
    mv.mv_ready = 1'b0;
    start = 1'b1;
    cyc = 0;
    @(negedge clk);
    start = 1'b0;
    while (!mv.mv_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (mv.mv_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: got valid %b required 1", mv.mv_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mv.mv_valid, busy} !== 2'b00 || sq_sel !== 6'd0) begin
      errors++;
      $display("FAIL rst_async: got valid %b busy %b sq %0d required 0 0 0",
               mv.mv_valid, busy, sq_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    mv.mv_ready = 1'b1;
    saw_done = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done || move_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_no_done: got done %b cnt %0d required 0 0", saw_done, move_count);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_sq28(1'b0, 0);
    test_sq28(1'b1, 0);
    test_sq28(1'b0, 2);
    test_random();
    test_saturation();
    test_start_busy();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
